// File: rtl/pb_debounce.sv
// Push-button debouncer with a two-flop synchronizer, press/release pulses and
// a long-press reset request (rst_req_n, active-low) for reset_synch.
module pb_debounce #(
    parameter int DB_CYCLES   = 50000,
    parameter int HOLD_CYCLES = 2000000,
    parameter int CNT_W       = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic PB_raw,
    output logic pb_level,
    output logic pb_press,
    output logic pb_release,
    output logic rst_req_n
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } state_t;

    localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic             ff1;
    logic             ff2;
    logic             sync;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] hold_cnt;

    // PB_raw is active-low: sync==0 means the button is pressed.
    always_comb sync = ff2;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff1        <= 1'b1;
            ff2        <= 1'b1;
            state      <= RELEASED;
            db_cnt     <= '0;
            hold_cnt   <= '0;
            pb_level   <= 1'b0;
            pb_press   <= 1'b0;
            pb_release <= 1'b0;
            rst_req_n  <= 1'b1;
        end else begin
            ff1        <= PB_raw;
            ff2        <= ff1;
            pb_press   <= 1'b0;
            pb_release <= 1'b0;

            case (state)
                RELEASED: begin
                    hold_cnt <= '0;
                    if (!sync) begin
                        state  <= PRESS_PEND;
                        db_cnt <= '0;
                    end
                end

                PRESS_PEND: begin
                    hold_cnt <= '0;
                    if (sync) begin
                        state  <= RELEASED;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_MAX) begin
                        state    <= PRESSED;
                        pb_press <= 1'b1;
                        pb_level <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + CNT_ONE;
                    end
                end

                PRESSED: begin
                    // Saturating hold counter; the request latches until release.
                    if (hold_cnt == HOLD_MAX) begin
                        rst_req_n <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_ONE;
                    end
                    if (sync) begin
                        state  <= RELEASE_PEND;
                        db_cnt <= '0;
                    end
                end

                RELEASE_PEND: begin
                    if (!sync) begin
                        state <= PRESSED;
                    end else if (db_cnt == DB_MAX) begin
                        state      <= RELEASED;
                        pb_release <= 1'b1;
                        pb_level   <= 1'b0;
                        rst_req_n  <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + CNT_ONE;
                    end
                end

                default: begin
                    state <= RELEASED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pb_debounce.sv
// Directed bench for pb_debounce with DB_CYCLES=4, HOLD_CYCLES=20, CNT_W=5.
module tb_pb_debounce;

    logic clk = 1'b0;
    logic rst;
    logic PB_raw;
    logic pb_level;
    logic pb_press;
    logic pb_release;
    logic rst_req_n;

    int tests = 0;
    int fails = 0;
    int press_seen = 0;
    int release_seen = 0;
    int p0;
    int r0;

    pb_debounce #(
        .DB_CYCLES  (4),
        .HOLD_CYCLES(20),
        .CNT_W      (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .PB_raw    (PB_raw),
        .pb_level  (pb_level),
        .pb_press  (pb_press),
        .pb_release(pb_release),
        .rst_req_n (rst_req_n)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pb_press === 1'b1) press_seen++;
        if (pb_release === 1'b1) release_seen++;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic ep, input logic er,
                        input logic el, input logic en);
        @(posedge clk);
        #1;
        chk({tag, ".press"},     pb_press,   ep);
        chk({tag, ".release"},   pb_release, er);
        chk({tag, ".level"},     pb_level,   el);
        chk({tag, ".rst_req_n"}, rst_req_n,  en);
    endtask

    task automatic steps(input int n, input string tag, input logic ep, input logic er,
                         input logic el, input logic en);
        for (int i = 0; i < n; i++) step(tag, ep, er, el, en);
    endtask

    initial begin
        // Reset with button held, then debounce and long press
        rst    = 1'b1;
        PB_raw = 1'b0;
        steps(2, "A.reset", 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        steps(6, "A.pend", 1'b0, 1'b0, 1'b0, 1'b1);
        step("A.press", 1'b1, 1'b0, 1'b1, 1'b1);
        steps(19, "A.hold", 1'b0, 1'b0, 1'b1, 1'b1);
        step("A.rstreq", 1'b0, 1'b0, 1'b1, 1'b0);
        steps(13, "A.held", 1'b0, 1'b0, 1'b1, 1'b0);
        PB_raw = 1'b1;
        steps(6, "A.relpend", 1'b0, 1'b0, 1'b1, 1'b0);
        step("A.release", 1'b0, 1'b1, 1'b0, 1'b1);
        step("A.idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // Clean press followed by a release bounce
        steps(2, "B.idle", 1'b0, 1'b0, 1'b0, 1'b1);
        r0 = release_seen;
        PB_raw = 1'b0;
        steps(6, "B.pend", 1'b0, 1'b0, 1'b0, 1'b1);
        step("B.press", 1'b1, 1'b0, 1'b1, 1'b1);
        step("B.pressed", 1'b0, 1'b0, 1'b1, 1'b1);
        PB_raw = 1'b1;
        steps(2, "B.rb_hi", 1'b0, 1'b0, 1'b1, 1'b1);
        PB_raw = 1'b0;
        step("B.rb_lo", 1'b0, 1'b0, 1'b1, 1'b1);
        PB_raw = 1'b1;
        steps(6, "B.rb_pend", 1'b0, 1'b0, 1'b1, 1'b1);
        step("B.release", 1'b0, 1'b1, 1'b0, 1'b1);
        step("B.idle", 1'b0, 1'b0, 1'b0, 1'b1);
        chk_int("B.release_count", release_seen - r0, 1);

        // Press bounce, then long press interrupted by reset
        steps(2, "C.idle", 1'b0, 1'b0, 1'b0, 1'b1);
        p0 = press_seen;
        PB_raw = 1'b0;
        steps(3, "C.pb_lo", 1'b0, 1'b0, 1'b0, 1'b1);
        PB_raw = 1'b1;
        step("C.pb_hi", 1'b0, 1'b0, 1'b0, 1'b1);
        PB_raw = 1'b0;
        steps(6, "C.pend", 1'b0, 1'b0, 1'b0, 1'b1);
        step("C.press", 1'b1, 1'b0, 1'b1, 1'b1);
        step("C.pressed", 1'b0, 1'b0, 1'b1, 1'b1);
        chk_int("C.press_count", press_seen - p0, 1);
        steps(18, "C.hold", 1'b0, 1'b0, 1'b1, 1'b1);
        step("C.rstreq", 1'b0, 1'b0, 1'b1, 1'b0);
        steps(2, "C.held", 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        step("D.reset", 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        steps(6, "D.pend", 1'b0, 1'b0, 1'b0, 1'b1);
        step("D.press", 1'b1, 1'b0, 1'b1, 1'b1);
        steps(19, "D.hold", 1'b0, 1'b0, 1'b1, 1'b1);
        step("D.rstreq", 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset lands on the edge where the release pulse would be due
        PB_raw = 1'b1;
        steps(6, "E.relpend", 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        step("E.reset", 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        steps(3, "E.idle", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pb_debounce.md
PB_DEBOUNCE -- requirements
Module: pb_debounce

Interface
REQ-001 Parameter DB_CYCLES, default 50000, SHALL set the number of consecutive stable synchronized samples needed to accept a level change.
REQ-002 Parameter HOLD_CYCLES, default 2000000, SHALL set the number of debounced-pressed cycles needed to raise a reset request.
REQ-003 Parameter CNT_W, default 22, SHALL set the counter width; the legal range is CNT_W >= clog2(HOLD_CYCLES+1), DB_CYCLES >= 2 and HOLD_CYCLES > DB_CYCLES.
REQ-004 clk  input  1  system clock; all state SHALL change on the rising edge only.
REQ-005 rst  input  1  reset; the block SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-006 PB_raw  input  1  asynchronous push-button level, active-low (0 = pressed).
REQ-007 pb_level  output  1  debounced, registered button level (1 = pressed).
REQ-008 pb_press  output  1  one-cycle pulse on an accepted press.
REQ-009 pb_release  output  1  one-cycle pulse on an accepted release.
REQ-010 rst_req_n  output  1  long-press reset request, active-low; it drives the RST_n input of reset_synch.

Function
REQ-011 PB_raw SHALL pass through two flops (ff1, then ff2) before any use; only ff2 ("sync") SHALL feed logic.
REQ-012 The FSM SHALL have four states: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
REQ-013 In RELEASED, sync==0 SHALL move the FSM to PRESS_PEND and clear db_cnt.
REQ-014 In PRESS_PEND:
- sync==1 SHALL return the FSM to RELEASED and clear db_cnt (bounce rejected).
- Otherwise, db_cnt==DB_CYCLES-1 SHALL move the FSM to PRESSED.
- Otherwise, db_cnt SHALL increment.
REQ-015 In PRESSED, sync==1 SHALL move the FSM to RELEASE_PEND and clear db_cnt.
REQ-016 In RELEASE_PEND:
- sync==0 SHALL return the FSM to PRESSED.
- Otherwise, db_cnt==DB_CYCLES-1 SHALL move the FSM to RELEASED.
- Otherwise, db_cnt SHALL increment.
REQ-017 pb_level SHALL be registered and equal 1 exactly while the FSM is in PRESSED or RELEASE_PEND.
REQ-018 pb_press SHALL be registered and be high for exactly the one cycle following the PRESS_PEND->PRESSED edge; pb_release SHALL behave the same for the RELEASE_PEND->RELEASED edge.
REQ-019 Latency: with PB_raw held low, pb_press and the pb_level rise SHALL appear after rising edge DB_CYCLES+3, counting the first edge that captures low into ff1 as edge 1; release latency SHALL be symmetric.
REQ-020 pb_press and pb_release SHALL never be high in the same cycle; their minimum spacing SHALL be DB_CYCLES+1 cycles.
REQ-021 hold_cnt SHALL:
- clear in RELEASED and PRESS_PEND;
- increment each cycle in PRESSED;
- hold its value in RELEASE_PEND;
- saturate at HOLD_CYCLES-1 and never wrap.
REQ-022 In PRESSED, hold_cnt==HOLD_CYCLES-1 SHALL drive rst_req_n low on that edge (registered).
REQ-023 Once low, rst_req_n SHALL stay low until the FSM enters RELEASED, then return to 1 on that same edge.
REQ-024 A bounce inside RELEASE_PEND SHALL NOT clear hold_cnt or deassert rst_req_n.
REQ-025 db_cnt SHALL never exceed DB_CYCLES-1 and SHALL never wrap.

Reset
REQ-026 While rst=1 at a rising edge, the block SHALL load:
- ff1 and ff2 = 1;
- FSM = RELEASED;
- db_cnt = 0 and hold_cnt = 0;
- pb_level = 0, pb_press = 0, pb_release = 0;
- rst_req_n = 1.
REQ-027 rst SHALL override every other condition in the same cycle, including a pulse or rst_req_n assertion that would otherwise be due.
REQ-028 If the button is still held low after rst deasserts, the block SHALL perform a full re-synchronization and debounce (REQ-019) before pb_press.

Verification (DB_CYCLES=4, HOLD_CYCLES=20, CNT_W=5)
REQ-029 Reset: rst=1 for 2 cycles with PB_raw=0 -> pb_level=0, rst_req_n=1, no pulses during reset; after rst falls, pb_press after edge 7.
REQ-030 Clean press: PB_raw 1->0, held low -> pb_press high one cycle after edge 7, pb_level=1 from then on.
REQ-031 Press bounce: PB_raw low 3 cycles, high 1, then low -> no pb_press until 7 edges after the final low capture; exactly one pb_press.
REQ-032 Release bounce: from pressed, PB_raw high 2 cycles, low 1, then high -> pb_level stays 1 through the bounce; exactly one pb_release, 7 edges after the final high capture.
REQ-033 Long press: PB_raw held low 60 cycles -> rst_req_n falls after edge 27, stays 0 while held; after release, rst_req_n=1 coincident with pb_release.
REQ-034 Reset mid-long-press: rst=1 for 1 cycle while rst_req_n=0 and PB_raw=0 -> rst_req_n=1 after that edge; pb_press recurs 7 edges after rst falls; rst_req_n falls again 20 edges after that.
